// File: rtl/rx_pack_pkg.sv
// rx_pack_pkg: shared types, word width and zero-to-one helper for the I/Q stream packer
package rx_pack_pkg;
  localparam int PACK_W = 64;
  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } iq_pair_t;
  typedef enum logic {PHASE0, PHASE1} pack_state_t;
  function automatic logic [31:0] eff_nonzero(input logic [31:0] v);
    return (v == '0) ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/rx_pack_fifo.sv
// rx_pack_fifo: synchronous first-word-fall-through FIFO with a registered valid flag
//   clk/rst    : clock, asynchronous active-high reset
//   wr_en_i    : write request; accepted when not full, or when full and a read happens this cycle
//   wr_data_i  : entry to store
//   rd_en_i    : consumer ready; a read happens only while valid_o is high
//   rd_data_o  : head entry, zero while nothing is valid
//   valid_o    : head entry is presented
//   level_o    : number of stored entries
//   full_o     : level_o == DEPTH
module rx_pack_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [W-1:0]              wr_data_i,
  input  logic                      rd_en_i,
  output logic [W-1:0]              rd_data_o,
  output logic                      valid_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          valid_q, wr, rd;
  assign rd      = rd_en_i && valid_q;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign wr      = wr_en_i && (!full_o || rd);
  assign level_d = level_q + (AW+1)'(wr) - (AW+1)'(rd);
  // valid follows the occupancy left after this cycle's read, so a word written
  // into an empty FIFO is presented one cycle after the write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      valid_q <= level_q != (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  assign rd_data_o = valid_q ? mem_q[rd_ptr_q] : '0;
  assign valid_o   = valid_q;
  assign level_o   = level_q;
endmodule

// File: rtl/rx_iq_stream_packer.sv
// rx_iq_stream_packer: decimates receiver I/Q, packs two pairs per 64-bit word and streams framed words
//   clock/reset         : sample clock, asynchronous active-high reset
//   enable              : capture enable; low flushes decimation, pack and frame state
//   sample_i/sample_q   : signed receiver samples, one per clock
//   dec_factor          : keep 1 of every dec_factor samples (0 acts as 1)
//   frame_len           : words per frame (0 acts as 1)
//   overflow_clr        : clears the sticky overflow flag
//   m_axis_*            : AXI-Stream master, tdata = {q1,i1,q0,i0}, pair 0 earlier
//   overflow            : sticky, a completed word was dropped on a full FIFO
//   fifo_level          : FIFO occupancy
module rx_iq_stream_packer
  import rx_pack_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [15:0]                  sample_i,
  input  logic [15:0]                  sample_q,
  input  logic [7:0]                   dec_factor,
  input  logic [FRAME_CNT_W-1:0]       frame_len,
  input  logic                         overflow_clr,
  output logic [PACK_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  logic [7:0]             dec_cnt_q, dec_cnt_d, dec_len_q, dec_len;
  logic [FRAME_CNT_W-1:0] word_cnt_q, word_cnt_d, eff_len;
  pack_state_t            state_q, state_d;
  iq_pair_t               lo_q;
  logic [PACK_W-1:0]      word_q;
  logic [PACK_W:0]        fifo_out;
  logic                   word_done_q, capture, cap_lo, cap_hi, tlast, full, rd, overflow_set, overflow_q;
  // the period length is sampled at the start of each period, so a new dec_factor lands on a wrap
  assign dec_len      = (dec_cnt_q == '0) ? 8'(eff_nonzero(32'(dec_factor))) : dec_len_q;
  assign capture      = enable && (dec_cnt_q == '0);
  assign dec_cnt_d    = (!enable || dec_cnt_q == dec_len - 8'd1) ? '0 : dec_cnt_q + 8'd1;
  assign eff_len      = FRAME_CNT_W'(eff_nonzero(32'(frame_len)));
  assign tlast        = word_cnt_q >= eff_len - FRAME_CNT_W'(1);
  // dropped words still count, keeping frame boundaries tied to time
  assign word_cnt_d   = !enable ? '0 : word_done_q ? (tlast ? '0 : word_cnt_q + FRAME_CNT_W'(1)) : word_cnt_q;
  assign rd           = m_axis_tvalid && m_axis_tready;
  assign overflow_set = word_done_q && full && !rd;
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= PHASE0;
    else       state_q <= state_d;
  always_comb
    state_d = !enable ? PHASE0 : !capture ? state_q : (state_q == PHASE0) ? PHASE1 : PHASE0;
  always_comb begin
    cap_lo = capture && state_q == PHASE0;
    cap_hi = capture && state_q == PHASE1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      dec_cnt_q   <= '0;
      dec_len_q   <= 8'd1;
      lo_q        <= '0;
      word_q      <= '0;
      word_done_q <= 1'b0;
      word_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      dec_len_q   <= dec_len;
      if (cap_lo) lo_q <= '{q: sample_q, i: sample_i};
      if (cap_hi) word_q <= {sample_q, sample_i, lo_q};
      word_done_q <= cap_hi;
      word_cnt_q  <= word_cnt_d;
      overflow_q  <= overflow_set || (overflow_q && !overflow_clr);
    end
  rx_pack_fifo #(
    .W     (PACK_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .wr_en_i   (word_done_q),
    .wr_data_i ({tlast, word_q}),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_out),
    .valid_o   (m_axis_tvalid),
    .level_o   (fifo_level),
    .full_o    (full)
  );
  assign {m_axis_tlast, m_axis_tdata} = fifo_out;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_rx_iq_stream_packer.sv
// tb_rx_iq_stream_packer: scoreboard bench with a sample-level reference model of the packer
module tb_rx_iq_stream_packer;
  localparam int DEPTH = 16;
  logic        clock = 0, reset = 1, enable = 0, overflow_clr = 0, m_axis_tready = 0;
  logic [15:0] sample_i = 0, sample_q = 0;
  logic [7:0]  dec_factor = 1;
  logic [15:0] frame_len = 4;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, overflow;
  logic [4:0]  fifo_level;
  int          checks = 0, errors = 0, pops = 0, k = 0, p0;
  logic [64:0] exp_q[$];
  int          s = 0, w = 0, m_level = 0;
  bit          have_lo = 0, pend = 0, m_ovf = 0, hs, drop;
  logic [31:0] lo_pair;
  logic [64:0] pend_word, got, exp_w, stall_word;
  bit          stall = 0;
  int          dec_eff, len_eff;

  rx_iq_stream_packer #(.FIFO_DEPTH(DEPTH), .FRAME_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sample_i(sample_i), .sample_q(sample_q),
    .dec_factor(dec_factor), .frame_len(frame_len), .overflow_clr(overflow_clr),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input bit ok, input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: decides at each falling edge what the coming rising edge does.
  // Captures are every dec-th enabled sample, pairs form words, words enter a
  // DEPTH-deep queue one edge after completion unless it is full with no read.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_level = 0; m_ovf = 0; s = 0; w = 0; have_lo = 0; pend = 0;
    end else begin
      chk(fifo_level == 5'(m_level), "fifo_level", fifo_level, m_level);
      chk(overflow == m_ovf, "overflow", overflow, m_ovf);
      hs = m_axis_tvalid && m_axis_tready;
      drop = 0;
      if (pend) begin
        if (m_level < DEPTH || hs) begin
          exp_q.push_back(pend_word);
          m_level++;
        end else drop = 1;
      end
      if (hs) m_level--;
      m_ovf = drop || (m_ovf && !overflow_clr);
      pend = 0;
      dec_eff = (dec_factor == 0) ? 1 : int'(dec_factor);
      len_eff = (frame_len == 0) ? 1 : int'(frame_len);
      if (enable) begin
        if (s % dec_eff == 0) begin
          if (!have_lo) begin
            lo_pair = {sample_q, sample_i};
            have_lo = 1;
          end else begin
            pend = 1;
            pend_word = {((w % len_eff) == len_eff - 1), sample_q, sample_i, lo_pair};
            w++;
            have_lo = 0;
          end
        end
        s++;
      end else begin
        s = 0; w = 0; have_lo = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks the hold rule while stalled.
  always @(negedge clock) begin
    if (reset) stall = 0;
    else begin
      got = {m_axis_tlast, m_axis_tdata};
      if (stall) chk(m_axis_tvalid && got == stall_word, "axis_hold", {m_axis_tvalid, got[63:0]}, {1'b1, stall_word[63:0]});
      if (m_axis_tvalid && m_axis_tready) begin
        pops++;
        if (exp_q.size() == 0) chk(0, "unexpected_word", got, 0);
        else begin
          exp_w = exp_q.pop_front();
          chk(got == exp_w, "word", got, exp_w);
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      stall_word = got;
    end
  end

  task automatic step(input bit en, input bit rdy, input bit rnd = 0, input bit clr = 0);
    @(posedge clock); #1;
    enable = en; m_axis_tready = rdy; overflow_clr = clr;
    if (rnd) begin
      sample_i = 16'($urandom); sample_q = 16'($urandom);
    end else begin
      sample_i = 16'(k); sample_q = 16'(-k);
    end
    if (en) k++;
  endtask

  task automatic run(input int n, input bit en, input int rdy, input bit rnd = 0);
    for (int j = 0; j < n; j++) step(en, (rdy == 2) ? 1'($urandom) : rdy[0], rnd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #3 reset = 0;
    chk(m_axis_tvalid == 0, "rst_tvalid", m_axis_tvalid, 0);
    chk(m_axis_tlast == 0, "rst_tlast", m_axis_tlast, 0);
    chk(m_axis_tdata == 0, "rst_tdata", m_axis_tdata, 0);
    chk(overflow == 0, "rst_overflow", overflow, 0);
    chk(fifo_level == 0, "rst_level", fifo_level, 0);
    // ramp, factor 1, frame 4: first word valid two edges after sample 1
    k = 0;
    step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    chk(m_axis_tvalid == 0, "latency_early", m_axis_tvalid, 0);
    step(1, 1);
    chk(m_axis_tvalid == 1, "latency_valid", m_axis_tvalid, 1);
    chk(m_axis_tdata == 64'hFFFF_0001_0000_0000, "first_word", m_axis_tdata, 64'hFFFF_0001_0000_0000);
    run(60, 1, 1);
    // factor 3
    run(3, 0, 1); dec_factor = 3; k = 0; run(40, 1, 1);
    // factor 0 and frame 0 act as 1
    run(3, 0, 1); dec_factor = 0; frame_len = 0; k = 0; run(30, 1, 1);
    // fill, overflow, drain, clear
    run(10, 0, 1); dec_factor = 1; frame_len = 4; k = 0;
    run(40, 1, 0); run(4, 0, 0);
    chk(fifo_level == 16, "full_level", fifo_level, 16);
    chk(overflow == 1, "overflow_set", overflow, 1);
    p0 = pops;
    run(30, 0, 1);
    chk(pops - p0 == 16, "drain_count", pops - p0, 16);
    step(0, 1, 0, 1); step(0, 1);
    chk(overflow == 0, "overflow_clr", overflow, 0);
    // randomised data, enable, ready, factor and frame length
    for (int b = 0; b < 5; b++) begin
      run(3, 0, 1);
      dec_factor = 8'($urandom_range(0, 4));
      frame_len = 16'($urandom_range(0, 5));
      for (int j = 0; j < 80; j++) step($urandom_range(0, 7) != 0, 1'($urandom), 1, $urandom_range(0, 40) == 0);
    end
    run(40, 0, 1);
    // frame alignment under drops: 7 words preloaded, then words 9..12 of a frame-8 stream drop
    dec_factor = 1; frame_len = 8; k = 0;
    run(14, 1, 0); run(3, 0, 0);
    k = 0; run(27, 1, 0); run(40, 1, 1); run(10, 0, 1);
    // enable dropped after the first sample of a pair
    frame_len = 4; k = 0;
    run(10, 1, 1); step(1, 1); run(2, 0, 1); run(20, 1, 1); run(10, 0, 1);
    // asynchronous reset with five words queued and overflow still set
    k = 0; run(10, 1, 0); run(3, 0, 0);
    chk(fifo_level == 5, "pre_reset_level", fifo_level, 5);
    chk(m_axis_tvalid == 1, "pre_reset_tvalid", m_axis_tvalid, 1);
    chk(overflow == 1, "pre_reset_overflow", overflow, 1);
    #2 reset = 1;
    #1;
    chk(m_axis_tvalid == 0, "async_rst_tvalid", m_axis_tvalid, 0);
    chk(fifo_level == 0, "async_rst_level", fifo_level, 0);
    chk(overflow == 0, "async_rst_overflow", overflow, 0);
    repeat (2) @(posedge clock);
    #3 reset = 0;
    k = 0; run(20, 1, 1); run(10, 0, 1);
    for (int j = 0; j < 100 && exp_q.size() != 0; j++) @(posedge clock);
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_iq_stream_packer.md
Name: rx_iq_stream_packer

Overview:
- Sits directly downstream of the RX baseband receiver; consumes its I/Q output (data_out1_i / data_out1_q) at the full `clock` rate.
- Decimates by a runtime factor and packs two I/Q pairs per 64-bit word.
- Buffers words in a small FIFO and presents them as an AXI-Stream master with backpressure, frame markers (tlast) and a sticky overflow flag for the DMA/capture path.

Parameters:
- FIFO_DEPTH, 16, number of 65-bit entries (64 data + tlast); power of two, >= 4.
- FRAME_CNT_W, 16, width of the frame-length input and the word counter.

Ports:
- clock  in  1  sample/processing clock; same clock as the baseband receiver output.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; 0 flushes the pack state.
- sample_i  in  16  signed I sample, from receiver data_out1_i.
- sample_q  in  16  signed Q sample, from receiver data_out1_q.
- dec_factor  in  8  keep 1 of every dec_factor samples; 0 is treated as 1.
- frame_len  in  FRAME_CNT_W  words per frame; 0 is treated as 1.
- overflow_clr  in  1  single-cycle clear of the overflow flag.
- m_axis_tdata  out  64  {q1,i1,q0,i0}; pair 0 is the earlier sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tlast  out  1  last word of a frame.
- m_axis_tready  in  1  AXI-Stream ready.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous use after release) clears all state:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, fifo_level=0.
  - Decimation counter=0, pack phase=0, frame word counter=0.
- Clocking: every rising edge presents a new sample; there is no input valid.
- Decimation:
  - The sample is captured when dec_cnt==0.
  - dec_cnt increments and wraps to 0 at (eff_dec-1), where eff_dec = max(dec_factor,1).
  - A dec_factor change takes effect at the next wrap.
- Pack state machine, two states:
  - PHASE0: capture {q,i} into the low half; go to PHASE1.
  - PHASE1: capture into the high half and assert word_done for one cycle; go to PHASE0.
- Frame counter:
  - On word_done, the word plus tlast is written to the FIFO on the following edge.
  - tlast = (word_cnt == eff_len-1), where eff_len = max(frame_len,1).
  - word_cnt increments on every word_done and wraps to 0 after the tlast word.
  - Dropped words still advance word_cnt, so frame boundaries stay aligned to time.
- enable=0:
  - dec_cnt, pack phase and word_cnt are held at 0; a partial word is discarded.
  - The FIFO keeps draining.
  - Capture restarts in PHASE0 on the first cycle enable=1.
- FIFO:
  - Synchronous, first-word-fall-through, implemented as rx_pack_fifo.
  - Write when word_done and not full.
  - A read occurs when m_axis_tvalid && m_axis_tready.
  - A simultaneous write and read at full is accepted as a write, because the read frees the slot in the same cycle; level is unchanged.
  - A simultaneous write and read at empty is not a read; the word appears with m_axis_tvalid on the next cycle.
- Latency: the edge capturing the second sample of a word is edge N. The word is written at N+1, and m_axis_tvalid is high after N+2 when the FIFO was empty.
- AXI-Stream rules:
  - tdata and tlast stay stable while tvalid && !tready.
  - tvalid never drops without a handshake, except on reset.
- Overflow:
  - word_done with the FIFO full and no read that cycle drops the word and sets overflow.
  - overflow_clr clears the flag; a set event in the same cycle wins (the flag stays 1).
- Arithmetic: samples pass bit-exact with no scaling or saturation.

Decomposition:
- Package rx_pack_pkg holds:
  - typedef iq_pair_t {logic signed [15:0] q; logic signed [15:0] i;};
  - typedef pack_state_t {PHASE0, PHASE1};
  - localparam PACK_W=64;
  - function eff_nonzero(), which maps 0 to 1.
- Sub-module rx_pack_fifo holds the parameterised FWFT FIFO: data, level, full and empty.
- The top level holds decimation, packing, framing, overflow and the AXI-Stream output.

Test Plan:
- Ramp input (i=k, q=-k), dec_factor=1, frame_len=4, tready=1:
  - First word {-1,1,0,0} with tvalid 2 cycles after sample 1.
  - tlast on words 3, 7, 11, …
- dec_factor=3, same ramp: word0 = {q=-3,i=3,q=0,i=0}; word1 contains samples 6 and 9.
- dec_factor=0 and frame_len=0: identical to factor 1, and tlast is set on every word.
- tready=0 with FIFO_DEPTH=16, dec_factor=1:
  - fifo_level reaches 16.
  - The 17th completed word is dropped and overflow=1.
  - Raising tready drains exactly 16 words, unchanged and in order.
  - overflow_clr then clears the flag.
- Frame alignment under drop: frame_len=8 with overflow during words 9..12 keeps tlast on word index 15, because the frame counter is time-aligned.
- enable pulled low after one sample of a pair, then re-raised: the partial sample is discarded and the next word starts with the first sample after re-enable.
- reset asserted while tvalid=1 and the FIFO holds 5 words: tvalid=0, fifo_level=0 and overflow=0 immediately, without waiting for a clock edge.
